dma_bus_arb: RTL and testbench

Two-port arbiter/sequencer that shares the single SD-host DMA bus (17-bit byte address, 8-bit data, pulsed `bus_rd`/`bus_wr`, delayed `bus_rdata_ready`, `bus_ready` busy indication) between the TX-fetch requester (port 0, memory reads) and the RX-store requester (port 1, memory writes, or any mix). It sits between the SDIO data engines and the DMA memory/bus server. It issues one access at a time, holds address and data stable for the whole access, returns read data, and times out hung accesses.

---
 rtl/dma_bus_arb.sv | 165 ++++++++++++++++
 tb/tb_dma_bus_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_arb.sv
// dma_bus_arb: round-robin arbiter/sequencer sharing the SD-host DMA bus
// between the TX-fetch requester (port 0) and the RX-store requester (port 1).
//
// Ports:
//   bus_clk, rstn           clock, synchronous active-low reset
//   pN_req/we/addr/wdata    requester command, held until pN_ack
//   pN_ack/err/rdata        one-cycle completion (err on timeout), read data
//   bus_addr/wdata/rd/wr    registered command to the DMA bus server
//   bus_ready               server idle
//   bus_rdata_ready/rdata   read data return pulse
module dma_bus_arb #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        bus_clk,
    input  logic        rstn,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [16:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_ack,
    output logic [7:0]  p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [16:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_ack,
    output logic [7:0]  p1_rdata,
    output logic        p1_err,
    output logic [16:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic        bus_ready,
    input  logic        bus_rdata_ready,
    input  logic [7:0]  bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        last;
    logic        gnt_id;
    logic        gnt_we;
    logic [7:0]  cnt;

    logic        grant;
    logic        pick;
    logic        rd_done;
    logic        wr_done;
    logic        cmpl;
    logic        tmo;

    // Register state.
    always_ff @(posedge bus_clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        // Contention goes to the port that was not served last.
        pick     = (p0_req && p1_req) ? ~last : p1_req;
        grant    = 1'b0;
        // cnt is 0 only on the first WAIT cycle, where completion is ignored.
        rd_done  = !gnt_we && bus_rdata_ready && (cnt != 8'd0);
        wr_done  = gnt_we && bus_ready && (cnt != 8'd0);
        cmpl     = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus_ready && (p0_req || p1_req)) begin
                    grant    = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                cmpl = rd_done || wr_done;
                tmo  = !cmpl && (cnt == 8'(TIMEOUT_CYC));
                if (cmpl || tmo) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (!rstn) begin
            last      <= 1'b1;
            gnt_id    <= 1'b0;
            gnt_we    <= 1'b0;
            cnt       <= 8'd0;
            bus_addr  <= 17'd0;
            bus_wdata <= 8'd0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            p0_rdata  <= 8'd0;
            p1_rdata  <= 8'd0;
        end else begin
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;

            // Command registered on grant so the pulse lands in ISSUE.
            if (grant) begin
                last      <= pick;
                gnt_id    <= pick;
                gnt_we    <= pick ? p1_we : p0_we;
                bus_addr  <= pick ? p1_addr : p0_addr;
                bus_wdata <= pick ? p1_wdata : p0_wdata;
                bus_rd    <= pick ? !p1_we : !p0_we;
                bus_wr    <= pick ? p1_we : p0_we;
            end

            if (state == S_ISSUE) begin
                cnt <= 8'd0;
            end

            if (state == S_WAIT) begin
                cnt <= cnt + 8'd1;
                if (rd_done) begin
                    if (gnt_id) begin
                        p1_rdata <= bus_rdata;
                    end else begin
                        p0_rdata <= bus_rdata;
                    end
                end
                // Ack/err registered so they appear during DONE.
                if (cmpl || tmo) begin
                    p0_ack <= !gnt_id;
                    p1_ack <= gnt_id;
                    p0_err <= tmo && !gnt_id;
                    p1_err <= tmo && gnt_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_bus_arb.sv
// tb_dma_bus_arb: table-driven, hand-written and randomized checks of
// dma_bus_arb against a 6-cycle DMA server model and a memory/round-robin model.
module tb_dma_bus_arb;

    localparam int TMO = 15;

    logic        bus_clk;
    logic        rstn;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [16:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [7:0]  p0_rdata, p1_rdata;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rd, bus_wr;
    logic        bus_ready;
    logic        bus_rdata_ready;
    logic [7:0]  bus_rdata;

    int checks = 0;
    int errors = 0;

    dma_bus_arb #(.TIMEOUT_CYC(TMO)) dut (
        .bus_clk         (bus_clk),
        .rstn            (rstn),
        .p0_req          (p0_req),
        .p0_we           (p0_we),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p0_ack          (p0_ack),
        .p0_rdata        (p0_rdata),
        .p0_err          (p0_err),
        .p1_req          (p1_req),
        .p1_we           (p1_we),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p1_ack          (p1_ack),
        .p1_rdata        (p1_rdata),
        .p1_err          (p1_err),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_rd          (bus_rd),
        .bus_wr          (bus_wr),
        .bus_ready       (bus_ready),
        .bus_rdata_ready (bus_rdata_ready),
        .bus_rdata       (bus_rdata)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    // ---------------- server model: 6 busy cycles per access ----------------
    logic [7:0]  smem [int];
    int          srv_cnt = 0;
    logic        srv_isrd = 1'b0;
    logic [16:0] srv_addr = 17'd0;
    logic        srv_rrdy = 1'b0;
    logic [7:0]  srv_rdata = 8'd0;
    logic        hang = 1'b0;
    logic        force_busy = 1'b0;
    logic        pl_en = 1'b0;
    logic [16:0] pl_addr = 17'd0;
    logic [7:0]  pl_data = 8'd0;

    assign bus_ready       = !force_busy && (srv_cnt == 0);
    assign bus_rdata_ready = srv_rrdy;
    assign bus_rdata       = srv_rdata;

    always @(posedge bus_clk) begin
        srv_rrdy <= 1'b0;
        if (pl_en) smem[int'(pl_addr)] = pl_data;
        if (srv_cnt != 0) begin
            srv_cnt <= srv_cnt - 1;
            if (srv_cnt == 1 && srv_isrd && !hang) begin
                srv_rrdy  <= 1'b1;
                srv_rdata <= smem.exists(int'(srv_addr)) ? smem[int'(srv_addr)] : 8'h00;
            end
        end else if (bus_rd || bus_wr) begin
            srv_cnt  <= 6;
            srv_isrd <= bus_rd;
            srv_addr <= bus_addr;
            if (bus_wr) smem[int'(bus_addr)] = bus_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [int];
    logic       rr_last;
    logic [7:0] xr0, xr1;

    function automatic logic [7:0] ref_rd(input logic [16:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    // Serve the requesting ports in round-robin order; predict read data.
    task automatic model_apply(input logic [1:0] mask,
                               input logic w0, input logic [16:0] a0, input logic [7:0] d0,
                               input logic w1, input logic [16:0] a1, input logic [7:0] d1,
                               output logic xf);
        logic p;
        xf = (mask == 2'b11) ? ~rr_last : mask[1];
        for (int i = 0; i < 2; i++) begin
            p = (i == 0) ? xf : ~xf;
            if (mask[p]) begin
                if (p == 1'b0) begin
                    if (w0) ref_mem[int'(a0)] = d0;
                    else    xr0 = ref_rd(a0);
                end else begin
                    if (w1) ref_mem[int'(a1)] = d1;
                    else    xr1 = ref_rd(a1);
                end
                rr_last = p;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Drive one request (or a simultaneous pair) and observe everything.
    task automatic run(input logic [1:0] mask,
                       input logic w0, input logic [16:0] a0, input logic [7:0] d0,
                       input logic w1, input logic [16:0] a1, input logic [7:0] d1,
                       input logic xf,
                       output int lat0, output int lat1,
                       output logic e0, output logic e1,
                       output logic [7:0] r0, output logic [7:0] r1,
                       output logic fst, output logic ok);
        logic [1:0]  pend;
        int          np, ack_k;
        logic        act, cur, cw, got;
        logic [16:0] ca;
        logic [7:0]  cd;
        lat0 = -1; lat1 = -1; e0 = 0; e1 = 0; fst = 0; ok = 1;
        np = 0; ack_k = -1; act = 0; cur = 0; cw = 0; got = 0; ca = 0; cd = 0;
        p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_we = w1; p1_addr = a1; p1_wdata = d1;
        p0_req = mask[0]; p1_req = mask[1];
        pend = mask;
        for (int k = 1; k <= 60 && pend != 2'b00; k++) begin
            @(negedge bus_clk);
            if (bus_rd || bus_wr) begin
                np++;
                cur = (np == 1) ? xf : ~xf;
                cw = cur ? w1 : w0;
                ca = cur ? a1 : a0;
                cd = cur ? d1 : d0;
                if (k != ((np == 1) ? 1 : ack_k + 2)) ok = 0;
                if (np > 2 || act || !mask[cur]) ok = 0;
                if (bus_rd == cw || bus_wr != cw) ok = 0;
                act = 1;
            end
            if (act && (bus_addr != ca || (cw && bus_wdata != cd))) ok = 0;
            if ((p0_err && !p0_ack) || (p1_err && !p1_ack)) ok = 0;
            if (p0_ack || p1_ack) begin
                if (!act || (p0_ack && p1_ack) || p1_ack != cur) ok = 0;
                if (!got) fst = p1_ack;
                got = 1;
                act = 0;
                ack_k = k;
            end
            if (p0_ack) begin
                lat0 = k; e0 = p0_err; p0_req = 0; pend[0] = 0;
            end
            if (p1_ack) begin
                lat1 = k; e1 = p1_err; p1_req = 0; pend[1] = 0;
            end
        end
        @(negedge bus_clk);
        r0 = p0_rdata;
        r1 = p1_rdata;
    endtask

    task automatic check_run(input string nm, input logic [1:0] mask, input logic xf,
                             input logic [7:0] x0, input logic [7:0] x1,
                             input logic xerr, input int tlat,
                             input int lat0, input int lat1,
                             input logic e0, input logic e1,
                             input logic [7:0] r0, input logic [7:0] r1,
                             input logic fst, input logic ok);
        if (mask[0]) begin
            chk({nm, "_lat0"}, lat0, (mask == 2'b11 && xf) ? tlat + 10 : tlat);
            chk({nm, "_err0"}, {31'd0, e0}, {31'd0, xerr});
        end
        if (mask[1]) begin
            chk({nm, "_lat1"}, lat1, (mask == 2'b11 && !xf) ? tlat + 10 : tlat);
            chk({nm, "_err1"}, {31'd0, e1}, {31'd0, xerr});
        end
        chk({nm, "_rd0"}, {24'd0, r0}, {24'd0, x0});
        chk({nm, "_rd1"}, {24'd0, r1}, {24'd0, x1});
        if (mask == 2'b11) chk({nm, "_order"}, {31'd0, fst}, {31'd0, xf});
        chk({nm, "_bus"}, {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic        w0;
        logic [16:0] a0;
        logic [7:0]  d0;
        logic        w1;
        logic [16:0] a1;
        logic [7:0]  d1;
        logic [7:0]  x0;
        logic [7:0]  x1;
        logic        first;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          lat0, lat1, n;
        logic        e0, e1, fst, ok, xf, seen;
        logic [7:0]  r0, r1, keep;
        logic [1:0]  mask;
        logic        w0, w1;
        logic [16:0] a0, a1;
        logic [7:0]  d0, d1;

        tbl[0] = '{2'b11, 1'b0, 17'h00010, 8'h00, 1'b1, 17'h1FFFF, 8'h3C, 8'hA5, 8'h00, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 17'h1FFFF, 8'h00, 1'b0, 17'h00000, 8'h00, 8'h3C, 8'h00, 1'b0};
        tbl[2] = '{2'b11, 1'b1, 17'h00100, 8'h11, 1'b0, 17'h00100, 8'h00, 8'h3C, 8'h00, 1'b1};
        tbl[3] = '{2'b11, 1'b0, 17'h00100, 8'h00, 1'b1, 17'h00100, 8'h77, 8'h77, 8'h00, 1'b1};
        tbl[4] = '{2'b10, 1'b0, 17'h00000, 8'h00, 1'b0, 17'h1FFFF, 8'h00, 8'h77, 8'h3C, 1'b1};

        rstn = 0;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        rr_last = 1; xr0 = 0; xr1 = 0;

        // Preload memory word used by the first read.
        @(negedge bus_clk);
        pl_addr = 17'h00010; pl_data = 8'hA5; pl_en = 1;
        ref_mem[32'h10] = 8'hA5;
        @(negedge bus_clk);
        pl_en = 0;
        @(negedge bus_clk);

        chk("rst_ctl", {26'd0, p0_ack, p1_ack, p0_err, p1_err, bus_rd, bus_wr}, 32'd0);
        chk("rst_addr", {15'd0, bus_addr}, 32'd0);
        chk("rst_wdata", {24'd0, bus_wdata}, 32'd0);
        chk("rst_rdata", {16'd0, p0_rdata, p1_rdata}, 32'd0);
        rstn = 1;
        @(negedge bus_clk);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            model_apply(tbl[i].mask, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                        tbl[i].w1, tbl[i].a1, tbl[i].d1, xf);
            run(tbl[i].mask, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].first,
                lat0, lat1, e0, e1, r0, r1, fst, ok);
            check_run($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].first,
                      tbl[i].x0, tbl[i].x1, 1'b0, 9,
                      lat0, lat1, e0, e1, r0, r1, fst, ok);
        end

        // Busy server holds off the grant.
        force_busy = 1;
        p0_we = 0; p0_addr = 17'h00010; p0_req = 1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge bus_clk);
            if (bus_rd || bus_wr || p0_ack) seen = 1;
        end
        chk("busy_hold", {31'd0, seen}, 32'd0);
        force_busy = 0;
        model_apply(2'b01, 1'b0, 17'h00010, 8'h00, 1'b0, 17'h0, 8'h00, xf);
        run(2'b01, 1'b0, 17'h00010, 8'h00, 1'b0, 17'h0, 8'h00, xf,
            lat0, lat1, e0, e1, r0, r1, fst, ok);
        check_run("busy", 2'b01, xf, xr0, xr1, 1'b0, 9,
                  lat0, lat1, e0, e1, r0, r1, fst, ok);

        // Timeout: read data never returns.
        hang = 1;
        keep = xr0;
        run(2'b01, 1'b0, 17'h1FFFF, 8'h00, 1'b0, 17'h0, 8'h00, 1'b0,
            lat0, lat1, e0, e1, r0, r1, fst, ok);
        rr_last = 0;
        check_run("tmo", 2'b01, 1'b0, keep, xr1, 1'b1, TMO + 3,
                  lat0, lat1, e0, e1, r0, r1, fst, ok);
        hang = 0;
        model_apply(2'b01, 1'b0, 17'h1FFFF, 8'h00, 1'b0, 17'h0, 8'h00, xf);
        run(2'b01, 1'b0, 17'h1FFFF, 8'h00, 1'b0, 17'h0, 8'h00, xf,
            lat0, lat1, e0, e1, r0, r1, fst, ok);
        check_run("post_tmo", 2'b01, xf, xr0, xr1, 1'b0, 9,
                  lat0, lat1, e0, e1, r0, r1, fst, ok);

        // Reset four cycles after the read pulse.
        p0_we = 0; p0_addr = 17'h00010; p0_req = 1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge bus_clk);
            if (bus_rd) seen = 1;
        end
        chk("mid_rd_seen", {31'd0, seen}, 32'd1);
        repeat (4) @(negedge bus_clk);
        rstn = 0;
        p0_req = 0;
        @(negedge bus_clk);
        chk("mid_rst_ctl", {26'd0, p0_ack, p1_ack, p0_err, p1_err, bus_rd, bus_wr}, 32'd0);
        chk("mid_rst_addr", {15'd0, bus_addr}, 32'd0);
        chk("mid_rst_rdata", {16'd0, p0_rdata, p1_rdata}, 32'd0);
        rstn = 1;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge bus_clk);
            if (p0_ack || p1_ack || bus_rd || bus_wr) n++;
        end
        chk("mid_rst_quiet", n, 0);
        rr_last = 1; xr0 = 0; xr1 = 0;

        // Randomized mixes against the reference model.
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(1, 3));
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            case ($urandom_range(0, 4))
                0: a0 = 17'h00010;
                1: a0 = 17'h00100;
                2: a0 = 17'h1FFFF;
                3: a0 = 17'h00000;
                default: a0 = 17'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: a1 = 17'h00010;
                1: a1 = 17'h00100;
                2: a1 = 17'h1FFFF;
                3: a1 = a0;
                default: a1 = 17'($urandom);
            endcase
            model_apply(mask, w0, a0, d0, w1, a1, d1, xf);
            run(mask, w0, a0, d0, w1, a1, d1, xf,
                lat0, lat1, e0, e1, r0, r1, fst, ok);
            check_run($sformatf("rnd%0d", it), mask, xf, xr0, xr1, 1'b0, 9,
                      lat0, lat1, e0, e1, r0, r1, fst, ok);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
